// File: rtl/uart_tx_engine.sv
// UART frame serialiser: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Frame settings are captured at start_tx, so the register block may change them mid-frame.
module uart_tx_engine #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_tx,
    input  logic [7:0] tx_data_in,
    input  logic [4:0] cfg_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [2:0]       bit_idx, idx_nxt, idx_inc, last_idx;
    logic [7:0]       sh_data, sh_data_nxt;
    logic [4:0]       sh_cfg, sh_cfg_nxt;
    logic             tx_nxt, busy_nxt, done_nxt, div_tc;

    // Only the low N = 5 + len bits take part in the parity sum.
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] len,
                                        input logic odd);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - len);
        return (^(d & mask)) ^ odd;
    endfunction

    assign div_tc   = (div_cnt == DIV_LAST);
    assign last_idx = 3'd4 + {1'b0, sh_cfg[1:0]};
    assign idx_inc  = bit_idx + 3'd1;

    always_comb begin
        state_nxt   = state;
        div_nxt     = div_tc ? '0 : div_cnt + 1'b1;
        idx_nxt     = bit_idx;
        sh_data_nxt = sh_data;
        sh_cfg_nxt  = sh_cfg;
        tx_nxt      = tx;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                div_nxt  = '0;
                idx_nxt  = '0;
                if (start_tx) begin
                    sh_data_nxt = tx_data_in;
                    sh_cfg_nxt  = cfg_in;
                    state_nxt   = START;
                    busy_nxt    = 1'b1;
                    tx_nxt      = 1'b0;
                end
            end
            START: begin
                if (div_tc) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                    tx_nxt    = sh_data[0];
                end
            end
            DATA: begin
                if (div_tc) begin
                    if (bit_idx == last_idx) begin
                        idx_nxt = '0;
                        if (sh_cfg[3]) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_bit(sh_data, sh_cfg[1:0], sh_cfg[4]);
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx_inc;
                        tx_nxt  = sh_data[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (div_tc) begin
                    state_nxt = STOP;
                    idx_nxt   = '0;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                // bit_idx doubles as the stop-bit counter for 2-stop-bit frames.
                if (div_tc) begin
                    if (sh_cfg[2] && bit_idx == 3'd0) begin
                        idx_nxt = 3'd1;
                    end else begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            sh_data <= '0;
            sh_cfg  <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_idx <= idx_nxt;
            sh_data <= sh_data_nxt;
            sh_cfg  <= sh_cfg_nxt;
            tx      <= tx_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine at CLK_DIV=4: expected frames are queued when a
// start is driven and compared bit by bit as the serial line produces them.
module tb_uart_tx_engine;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_tx = 1'b0;
    logic [7:0] tx_data_in = '0;
    logic [4:0] cfg_in = '0;
    logic       tx, tx_busy, tx_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
    } frame_t;

    frame_t exp_q[$];

    uart_tx_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start_tx(start_tx), .tx_data_in(tx_data_in),
        .cfg_in(cfg_in), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t model_frame(input logic [7:0] d, input logic [4:0] c);
        frame_t f;
        int n, k;
        logic par;
        f.bits = '0;
        n = 5 + int'(c[1:0]);
        k = 0;
        par = c[4];
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i]; k++;
            par ^= d[i];
        end
        if (c[3]) begin f.bits[k] = par; k++; end
        f.bits[k] = 1'b1; k++;
        if (c[2]) begin f.bits[k] = 1'b1; k++; end
        f.nbits = k;
        return f;
    endfunction

    task automatic send(input logic [7:0] d, input logic [4:0] c);
        @(negedge clk);
        start_tx = 1'b1;
        tx_data_in = d;
        cfg_in = c;
        exp_q.push_back(model_frame(d, c));
        @(negedge clk);
        start_tx = 1'b0;
    endtask

    task automatic mon_frame(input string tag);
        frame_t e;
        logic [31:0] got, mask;
        int t, len, bi;
        logic busy_ok;
        t = 0;
        while (tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            check_val({tag, "_start_timeout"}, 32'(tx), 0);
            return;
        end
        if (exp_q.size() == 0) begin
            check_val({tag, "_unexpected_frame"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        got = '0;
        busy_ok = 1'b1;
        len = 0;
        bi = 0;
        while (tx_done !== 1'b1 && len < 200) begin
            if (len % CLK_DIV == 1 && bi < 32) begin
                got[bi] = tx;
                bi++;
            end
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            len++;
        end
        mask = (e.nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << e.nbits) - 32'd1);
        check_val({tag, "_len"}, len, CLK_DIV * e.nbits);
        check_val({tag, "_bits"}, got & mask, e.bits);
        check_val({tag, "_busy_in_frame"}, 32'(busy_ok), 1);
        check_val({tag, "_busy_at_done"}, 32'(tx_busy), 0);
        check_val({tag, "_tx_at_done"}, 32'(tx), 1);
        @(negedge clk);
        check_val({tag, "_done_one_cycle"}, 32'(tx_done), 0);
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        logic ok;
        ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
        end
        check_val(tag, 32'(ok), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_tx", 32'(tx), 1);
        check_val("rst_busy", 32'(tx_busy), 0);
        check_val("rst_done", 32'(tx_done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet_window("idle_after_reset", 5);

        // 8N1 0x55
        fork
            send(8'h55, 5'b00011);
            mon_frame("t1_8n1");
        join
        check_val("t1_len_literal", 32'(model_frame(8'h55, 5'b00011).nbits * CLK_DIV), 40);

        // 5E2 0x1B: upper data bits ignored
        fork
            send(8'h1B, 5'b01100);
            mon_frame("t2_5e2");
        join

        // 8O1 and 8E1 0x07
        fork
            send(8'h07, 5'b11011);
            mon_frame("t3_8o1");
        join
        fork
            send(8'h07, 5'b01011);
            mon_frame("t3_8e1");
        join

        // 6 data bits, odd parity, 2 stop bits
        fork
            send(8'hE9, 5'b11101);
            mon_frame("t3_6o2");
        join

        // start while busy is ignored
        fork
            begin
                send(8'h3C, 5'b00011);
                repeat (10) @(negedge clk);
                start_tx = 1'b1;
                tx_data_in = 8'hFF;
                cfg_in = 5'b11100;
                @(negedge clk);
                start_tx = 1'b0;
            end
            mon_frame("t4_busy");
        join
        quiet_window("t4_no_second_frame", 30);

        // start_tx held high: back-to-back frames, each resampling inputs
        fork
            begin
                @(negedge clk);
                start_tx = 1'b1;
                tx_data_in = 8'hA3;
                cfg_in = 5'b00011;
                exp_q.push_back(model_frame(8'hA3, 5'b00011));
                @(negedge clk);
                tx_data_in = 8'h12;
                cfg_in = 5'b11010;
                exp_q.push_back(model_frame(8'h12, 5'b11010));
                for (int w = 0; w < 200 && tx_done !== 1'b1; w++) @(negedge clk);
                @(negedge clk);
                start_tx = 1'b0;
            end
            begin
                mon_frame("t4_b2b_a");
                check_val("t4_b2b_gap", 32'(tx), 0);
                mon_frame("t4_b2b_b");
            end
        join
        quiet_window("t4_b2b_stop", 20);

        // reset during DATA aborts asynchronously
        send(8'hA5, 5'b00011);
        repeat (9) @(negedge clk);
        check_val("t5_pre_tx", 32'(tx), 0);
        check_val("t5_pre_busy", 32'(tx_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("t5_async_tx", 32'(tx), 1);
        check_val("t5_async_busy", 32'(tx_busy), 0);
        check_val("t5_async_done", 32'(tx_done), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        quiet_window("t5_no_frame_after_reset", 60);

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
